// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier, signed or unsigned per operation.
// One add/sub-and-shift per cycle over WIDTH+1 iterations with a start/busy/done handshake.
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH+1:0]     r_a;
    logic [WIDTH:0]       r_q;
    logic [WIDTH:0]       r_m;
    logic                 r_q_1;
    logic [CW-1:0]        r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_out;

    logic [WIDTH:0]       w_in1_ext;
    logic [WIDTH:0]       w_in2_ext;
    logic [WIDTH+1:0]     w_m_ext;
    logic [WIDTH+1:0]     w_sum;
    logic [WIDTH+1:0]     w_a_sh;
    logic [WIDTH:0]       w_q_sh;
    logic                 w_last;

    // Extending by one bit lets the signed Booth recoding also cover unsigned operands exactly.
    assign w_in1_ext = {is_signed & in1[WIDTH-1], in1};
    assign w_in2_ext = {is_signed & in2[WIDTH-1], in2};
    assign w_m_ext   = {r_m[WIDTH], r_m};

    always_comb begin
        w_sum = r_a;
        unique case ({r_q[0], r_q_1})
            2'b01:   w_sum = r_a + w_m_ext;
            2'b10:   w_sum = r_a - w_m_ext;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_sh = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign w_q_sh = {w_sum[0], r_q[WIDTH:1]};
    assign w_last = (r_count == CW'(WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_q_1   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m     <= w_in1_ext;
                        r_q     <= w_in2_ext;
                        r_a     <= '0;
                        r_q_1   <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a     <= w_a_sh;
                    r_q     <= w_q_sh;
                    r_q_1   <= r_q[0];
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        // Low 2*WIDTH bits of the shifted {A,Q} are the exact product in both modes.
                        r_out   <= {w_a_sh[WIDTH-2:0], w_q_sh};
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and small randomised checks of booth_multiplier_seq at WIDTH=32 and WIDTH=8.
module tb_booth_multiplier_seq;

    logic        clk;
    logic        reset;

    logic        start32, sgn32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] out32;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int n_checks;
    int n_errors;
    logic done32_prev, done8_prev;

    booth_multiplier_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .in1(a32), .in2(b32), .busy(busy32), .done(done32), .out(out32)
    );

    booth_multiplier_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .in1(a8), .in2(b8), .busy(busy8), .done(done8), .out(out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit w8, input logic [63:0] a,
                                          input logic [63:0] b, input bit sgn);
        logic [63:0] ax, bx, p;
        if (w8) begin
            ax = sgn ? {{56{a[7]}}, a[7:0]} : {56'b0, a[7:0]};
            bx = sgn ? {{56{b[7]}}, b[7:0]} : {56'b0, b[7:0]};
            p  = ax * bx;
            return {48'b0, p[15:0]};
        end
        ax = sgn ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
        bx = sgn ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
        return ax * bx;
    endfunction

    // Protocol monitor: done is a single-cycle pulse and never overlaps busy.
    always @(negedge clk) begin
        if (reset) begin
            if (done32) begin
                check("done32_busy", {63'b0, busy32}, 64'd0);
                check("done32_pulse", {63'b0, done32_prev}, 64'd0);
            end
            if (done8) begin
                check("done8_busy", {63'b0, busy8}, 64'd0);
                check("done8_pulse", {63'b0, done8_prev}, 64'd0);
            end
        end
        done32_prev <= done32;
        done8_prev  <= done8;
    end

    task automatic run_op(input bit w8, input logic [63:0] a, input logic [63:0] b,
                          input bit sgn, input logic [63:0] exp, input string tag);
        int lat;
        logic [63:0] got;
        lat = -1;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sgn8 = sgn;
        end else begin
            start32 = 1'b1; a32 = a[31:0]; b32 = b[31:0]; sgn32 = sgn;
        end
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        check({tag, "_busy"}, {63'b0, (w8 ? busy8 : busy32)}, 64'd1);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (w8 ? done8 : done32) begin
                lat = k;
                break;
            end
        end
        got = w8 ? {48'b0, out8} : out32;
        check({tag, "_lat"}, 64'(lat), (w8 ? 64'd9 : 64'd33));
        check({tag, "_out"}, got, exp);
        $display("op %s w=%0d a=0x%0h b=0x%0h s=%0d out=0x%0h lat=%0d",
                 tag, (w8 ? 8 : 32), a, b, sgn, got, lat);
    endtask

    initial begin
        int lat;
        logic [63:0] ra, rb;
        bit rs;
        n_checks = 0; n_errors = 0;
        reset = 1'b0;
        start32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
        start8 = 0;  sgn8 = 0;  a8 = '0;  b8 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy32", {63'b0, busy32}, 64'd0);
        check("rst_done32", {63'b0, done32}, 64'd0);
        check("rst_out32", out32, 64'd0);
        check("rst_out8", {48'b0, out8}, 64'd0);

        run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, "u32_max");
        run_op(0, 64'h8000_0000, 64'd2, 0, 64'h0000_0001_0000_0000, "u32_msb_x2");
        run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'h0000_0000_0000_0001, "s32_m1xm1");
        run_op(0, 64'h8000_0000, 64'h8000_0000, 1, 64'h4000_0000_0000_0000, "s32_minxmin");
        run_op(0, 64'hFFFF_FFFD, 64'd5, 1, 64'hFFFF_FFFF_FFFF_FFF1, "s32_m3x5");

        // Reset mid-run discards the operation and clears out.
        @(negedge clk);
        start32 = 1'b1; a32 = 32'd7; b32 = 32'd9; sgn32 = 1'b0;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy32}, 64'd0);
        check("midrst_done", {63'b0, done32}, 64'd0);
        check("midrst_out", out32, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(0, 64'd7, 64'd9, 0, 64'h0000_0000_0000_003F, "u32_7x9");

        // start while busy must be ignored.
        @(negedge clk);
        start32 = 1'b1; a32 = 32'd3; b32 = 32'd4; sgn32 = 1'b0;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin
                start32 = 1'b1; a32 = 32'd99; b32 = 32'hFFFF_FF00; sgn32 = 1'b1;
            end
            if (k == 6) start32 = 1'b0;
            @(posedge clk); #1;
            if (done32) begin
                lat = k;
                break;
            end
        end
        check("ignore_lat", 64'(lat), 64'd33);
        check("ignore_out", out32, 64'd12);
        $display("op ignore_busy_start w=32 out=0x%0h lat=%0d", out32, lat);

        // Back-to-back: start raised in the done cycle.
        run_op(0, 64'd6, 64'd7, 0, 64'd42, "b2b_first");
        start32 = 1'b1; a32 = 32'd11; b32 = 32'd13; sgn32 = 1'b0;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = -1;
        for (int k = 2; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done32) begin
                lat = k;
                break;
            end
        end
        check("b2b_gap", 64'(lat), 64'd34);
        check("b2b_out", out32, 64'd143);
        $display("op b2b_second w=32 out=0x%0h gap=%0d", out32, lat);

        run_op(1, 64'h80, 64'h7F, 1, 64'h0000_0000_0000_C080, "s8_minx127");
        run_op(1, 64'hFF, 64'hFF, 0, 64'h0000_0000_0000_FE01, "u8_max");
        run_op(1, 64'hFF, 64'hFF, 1, 64'h0000_0000_0000_0001, "s8_m1xm1");
        run_op(1, 64'h80, 64'h80, 1, 64'h0000_0000_0000_4000, "s8_minxmin");

        for (int i = 0; i < 30; i++) begin
            ra = {32'b0, $urandom};
            rb = {32'b0, $urandom};
            rs = 1'($urandom_range(0, 1));
            run_op(0, ra, rb, rs, model(0, ra, rb, rs), $sformatf("rnd32_%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            run_op(1, ra, rb, rs, model(1, ra, rb, rs), $sformatf("rnd8_%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
